fust_multi: RTL and testbench
=============================

# fust_multi

Multi-entry functional-unit status table (FUST) for the scoreboard. It is the parametrised successor to the single-unit matrix FUST. The block tracks operand dependences for `NUM_FU` functional units:
- per-entry busy/issued state,
- destination and source register fields,
- producer tags (`qj`/`qk`).

It accepts dispatch writes, issue marks and writeback tag broadcasts, and publishes per-unit ready and busy vectors to the issue selector.

## Interface
Parameters:
- `NUM_FU`, 4: number of functional units / table entries (≥2).
- `REG_W`, 5: register index width.
- `FU_W`, `$clog2(NUM_FU)`: entry index width (derived).
- `TAG_W`, `$clog2(NUM_FU+1)`: producer tag width. Tag 0 means "no dependence"; tag k means FU k-1.

Ports:
- `CLK` in 1: the single clock; the table state updates on the falling edge.
- `nRST` in 1: reset, asynchronous, active-low.
- `dispatch_en` in 1: request to write an entry.
- `dispatch_fu` in `FU_W`: target entry.
- `dispatch_rd`, `dispatch_rs1`, `dispatch_rs2` in `REG_W`: register fields.
- `dispatch_qj`, `dispatch_qk` in `TAG_W`: producer tags for rs1/rs2.
- `dispatch_stall` out 1: dispatch rejected this cycle (combinational).
- `issue_en` in 1: mark entry as issued (operands read).
- `issue_fu` in `FU_W`: entry to issue.
- `issue_rd`, `issue_rs1`, `issue_rs2` out `REG_W`: fields of entry `issue_fu` (combinational read).
- `wb_en` in 1: writeback broadcast valid.
- `wb_tag` in `TAG_W`: tag of the completing FU.
- `busy` out `NUM_FU`: entry occupied.
- `ready` out `NUM_FU`: `busy & ~issued & (qj==0) & (qk==0)`, per entry.

## Operation
- **Entry state:** `busy`, `issued`, `rd`, `rs1`, `rs2`, `qj`, `qk`. Reset clears all fields to 0.
- **Entry lifecycle:** FREE (`busy`=0) → WAIT (`busy`=1, `issued`=0) → ISSUED (`busy`=1, `issued`=1) → FREE.
- **Dispatch:**
  - Accepted when `dispatch_en` and `dispatch_stall`=0.
  - Writes all fields, sets `busy`=1 and `issued`=0.
- **`dispatch_stall`:** asserted when `dispatch_en` and entry `dispatch_fu` is busy, unless that same entry is freed by writeback this cycle (`wb_en` and `wb_tag` = `dispatch_fu`+1).
- **Issue:**
  - Sets `issued`=1 on entry `issue_fu` only when that entry's `ready` bit is 1.
  - Otherwise issue is ignored and the entry is unchanged.
- **Writeback, when `wb_en` and 1 ≤ `wb_tag` ≤ `NUM_FU`:**
  - Entry `wb_tag`-1 returns to FREE: `busy`=0, `issued`=0.
  - Every entry with `qj`==`wb_tag` clears `qj` to 0; likewise `qk`.
  - `wb_tag`=0 or `wb_tag` > `NUM_FU` is ignored.
- **Priority on the same entry in the same edge:** dispatch > writeback > issue.
  - Writeback + issue on the same entry: the entry ends FREE.
  - Writeback + dispatch on the same entry: the entry ends WAIT with the new fields.
- **Width rules:**
  - Out-of-range `dispatch_fu`/`issue_fu` (≥ `NUM_FU`) is ignored; stall is 0 for out-of-range dispatch.
  - `issue_rd`, `issue_rs1`, `issue_rs2` read 0 for an out-of-range index.

## Timing
- All state registers on the falling edge of `CLK`. `ready` and `busy` are valid from the falling edge onward, for the following rising-edge consumer.
- Outputs derived from state: a dispatch written at falling edge N is visible in `busy` and `ready` immediately after edge N.
- `dispatch_stall` and the `issue_*` fields are combinational from inputs and current state, with zero latency.
- **Reset:**
  - `nRST` low asynchronously clears all entries.
  - Outputs during reset: `busy`=0, `ready`=0, `issue_*`=0, `dispatch_stall`=0.
  - Reset mid-operation discards all in-flight entries; nothing is replayed.
- **Simultaneous dispatch + writeback with `dispatch_qj`/`dispatch_qk` == `wb_tag`:** see Configuration.

## Configuration
- **`FUST_MULTI_WB_BYPASS_EN` defined:**
  - A dispatched `qj`/`qk` equal to a concurrent valid `wb_tag` is stored as 0 (forwarded).
  - The entry can be ready on the next cycle.
- **Undefined:**
  - `dispatch_stall` is additionally asserted when `wb_en` and (`dispatch_qj`==`wb_tag` or `dispatch_qk`==`wb_tag`) with a nonzero tag.
  - The dispatch retries the next cycle, when the producer is already cleared.
  - No stale tag is ever stored in either mode.

## Test plan
- **Reset/idle:**
  - Assert `nRST`=0 mid-run with 3 busy entries → `busy`=0000 and `ready`=0000 immediately.
  - Release → no change until dispatch.
- **Dispatch, issue, writeback:**
  - Dispatch FU2 (qj=0, qk=0) → `ready`=0100.
  - Issue FU2 → `ready`=0000, `busy`=0100.
  - `wb_tag`=3 → `busy`=0000.
- **Dependence clear:**
  - Dispatch FU0 with qj=2, qk=0 and FU1 busy → `ready[0]`=0.
  - `wb_tag`=2 → FU1 freed, `ready[0]`=1 next cycle.
- **Structural stall and same-cycle reuse:**
  - Dispatch to busy FU3 → `dispatch_stall`=1, entry unchanged.
  - Same dispatch with `wb_tag`=4 → `dispatch_stall`=0, FU3 WAIT with new fields.
- **Bypass macro:**
  - Dispatch FU0 qj=2 with concurrent `wb_tag`=2.
  - Defined → accepted, qj=0, `ready[0]`=1.
  - Undefined → `dispatch_stall`=1; the retry is accepted with qj cleared.
- **Ignored inputs:**
  - `wb_tag`=0 → no change.
  - Issue of a not-ready entry → no change.
  - `issue_fu`=`NUM_FU` → `issue_*`=0.

Source files
------------

// File: rtl/fust_multi.sv
// rtl/fust_multi.sv - multi-entry functional-unit status table for the scoreboard
// Ports:
//   CLK            single clock; table state updates on the falling edge
//   nRST           asynchronous active-low reset, clears every entry
//   dispatch_*     write an entry (rd/rs1/rs2 fields, qj/qk producer tags)
//   dispatch_stall dispatch rejected this cycle (combinational)
//   issue_en/fu    mark a ready entry issued
//   issue_rd/rs1/rs2  combinational read of entry issue_fu (0 when out of range)
//   wb_en/wb_tag   writeback broadcast; tag k frees FU k-1 and clears matching qj/qk
//   busy/ready     per-entry occupancy and issue readiness
// Optional feature macro: FUST_MULTI_WB_BYPASS_EN forwards a concurrent
//   writeback tag into the dispatched qj/qk instead of stalling the dispatch.
module fust_multi #(
  parameter int NUM_FU = 4,
  parameter int REG_W  = 5,
  parameter int FU_W   = $clog2(NUM_FU),
  parameter int TAG_W  = $clog2(NUM_FU + 1)
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              dispatch_en,
  input  logic [FU_W-1:0]   dispatch_fu,
  input  logic [REG_W-1:0]  dispatch_rd,
  input  logic [REG_W-1:0]  dispatch_rs1,
  input  logic [REG_W-1:0]  dispatch_rs2,
  input  logic [TAG_W-1:0]  dispatch_qj,
  input  logic [TAG_W-1:0]  dispatch_qk,
  output logic              dispatch_stall,
  input  logic              issue_en,
  input  logic [FU_W-1:0]   issue_fu,
  output logic [REG_W-1:0]  issue_rd,
  output logic [REG_W-1:0]  issue_rs1,
  output logic [REG_W-1:0]  issue_rs2,
  input  logic              wb_en,
  input  logic [TAG_W-1:0]  wb_tag,
  output logic [NUM_FU-1:0] busy,
  output logic [NUM_FU-1:0] ready
);

  // One extra bit on the index limit so NUM_FU itself is representable.
  localparam logic [FU_W:0]    FU_LIM  = (FU_W + 1)'(NUM_FU);
  localparam logic [TAG_W-1:0] TAG_MAX = TAG_W'(NUM_FU);

  logic [NUM_FU-1:0] busy_q;
  logic [NUM_FU-1:0] issued_q;
  logic [REG_W-1:0]  rd_q  [NUM_FU];
  logic [REG_W-1:0]  rs1_q [NUM_FU];
  logic [REG_W-1:0]  rs2_q [NUM_FU];
  logic [TAG_W-1:0]  qj_q  [NUM_FU];
  logic [TAG_W-1:0]  qk_q  [NUM_FU];

  logic              wb_valid;
  logic              disp_in_range;
  logic              disp_accept;
  logic              struct_stall;
  logic              dep_stall;
  logic [NUM_FU-1:0] disp_hit;
  logic [NUM_FU-1:0] free_hit;
  logic [NUM_FU-1:0] issue_hit;
  logic [NUM_FU-1:0] ready_int;
  logic [TAG_W-1:0]  new_qj;
  logic [TAG_W-1:0]  new_qk;

  always_comb begin
    wb_valid      = wb_en && (wb_tag != '0) && (wb_tag <= TAG_MAX);
    disp_in_range = ({1'b0, dispatch_fu} < FU_LIM);
    for (int i = 0; i < NUM_FU; i++) begin
      disp_hit[i]  = disp_in_range && (dispatch_fu == FU_W'(i));
      free_hit[i]  = wb_valid && (wb_tag == TAG_W'(i + 1));
      issue_hit[i] = issue_en && (issue_fu == FU_W'(i));
      ready_int[i] = busy_q[i] && !issued_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
    end
    // A busy target is still usable when writeback frees it on this same edge.
    struct_stall = |(disp_hit & busy_q & ~free_hit);
`ifdef FUST_MULTI_WB_BYPASS_EN
    dep_stall = 1'b0;
    new_qj    = (wb_valid && (dispatch_qj == wb_tag)) ? '0 : dispatch_qj;
    new_qk    = (wb_valid && (dispatch_qk == wb_tag)) ? '0 : dispatch_qk;
`else
    // Without forwarding, a tag completing this cycle would be stored stale; retry instead.
    dep_stall = wb_en && (wb_tag != '0) &&
                ((dispatch_qj == wb_tag) || (dispatch_qk == wb_tag));
    new_qj    = dispatch_qj;
    new_qk    = dispatch_qk;
`endif
    dispatch_stall = nRST && dispatch_en && disp_in_range && (struct_stall || dep_stall);
    disp_accept    = dispatch_en && disp_in_range && !dispatch_stall;
  end

  always_comb begin
    issue_rd  = '0;
    issue_rs1 = '0;
    issue_rs2 = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (issue_fu == FU_W'(i)) begin
        issue_rd  = rd_q[i];
        issue_rs1 = rs1_q[i];
        issue_rs2 = rs2_q[i];
      end
    end
  end

  always_ff @(negedge CLK or negedge nRST) begin
    if (!nRST) begin
      busy_q   <= '0;
      issued_q <= '0;
      for (int i = 0; i < NUM_FU; i++) begin
        rd_q[i]  <= '0;
        rs1_q[i] <= '0;
        rs2_q[i] <= '0;
        qj_q[i]  <= '0;
        qk_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (disp_accept && disp_hit[i]) begin
          // Dispatch wins over writeback and issue on the same entry.
          busy_q[i]   <= 1'b1;
          issued_q[i] <= 1'b0;
          rd_q[i]     <= dispatch_rd;
          rs1_q[i]    <= dispatch_rs1;
          rs2_q[i]    <= dispatch_rs2;
          qj_q[i]     <= new_qj;
          qk_q[i]     <= new_qk;
        end else begin
          if (free_hit[i]) begin
            busy_q[i]   <= 1'b0;
            issued_q[i] <= 1'b0;
          end else if (issue_hit[i] && ready_int[i]) begin
            issued_q[i] <= 1'b1;
          end
          if (wb_valid && (qj_q[i] == wb_tag)) qj_q[i] <= '0;
          if (wb_valid && (qk_q[i] == wb_tag)) qk_q[i] <= '0;
        end
      end
    end
  end

  assign busy  = busy_q;
  assign ready = ready_int;

endmodule

// File: tb/tb_fust_multi.sv
// tb/tb_fust_multi.sv - scoreboard bench for fust_multi (NUM_FU=4 main, NUM_FU=6 range checks)
module tb_fust_multi;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       nRST;
  logic       dispatch_en;
  logic [1:0] dispatch_fu;
  logic [4:0] dispatch_rd, dispatch_rs1, dispatch_rs2;
  logic [2:0] dispatch_qj, dispatch_qk;
  logic       dispatch_stall;
  logic       issue_en;
  logic [1:0] issue_fu;
  logic [4:0] issue_rd, issue_rs1, issue_rs2;
  logic       wb_en;
  logic [2:0] wb_tag;
  logic [3:0] busy, ready;

  logic       x_dispatch_en;
  logic [2:0] x_dispatch_fu;
  logic [4:0] x_dispatch_rd, x_dispatch_rs1, x_dispatch_rs2;
  logic [2:0] x_dispatch_qj, x_dispatch_qk;
  logic       x_dispatch_stall;
  logic       x_issue_en;
  logic [2:0] x_issue_fu;
  logic [4:0] x_issue_rd, x_issue_rs1, x_issue_rs2;
  logic       x_wb_en;
  logic [2:0] x_wb_tag;
  logic [5:0] x_busy, x_ready;

  fust_multi #(.NUM_FU(4), .REG_W(5)) dut (
    .CLK(CLK), .nRST(nRST),
    .dispatch_en(dispatch_en), .dispatch_fu(dispatch_fu),
    .dispatch_rd(dispatch_rd), .dispatch_rs1(dispatch_rs1), .dispatch_rs2(dispatch_rs2),
    .dispatch_qj(dispatch_qj), .dispatch_qk(dispatch_qk), .dispatch_stall(dispatch_stall),
    .issue_en(issue_en), .issue_fu(issue_fu),
    .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .wb_en(wb_en), .wb_tag(wb_tag), .busy(busy), .ready(ready)
  );

  fust_multi #(.NUM_FU(6), .REG_W(5)) dut_x (
    .CLK(CLK), .nRST(nRST),
    .dispatch_en(x_dispatch_en), .dispatch_fu(x_dispatch_fu),
    .dispatch_rd(x_dispatch_rd), .dispatch_rs1(x_dispatch_rs1), .dispatch_rs2(x_dispatch_rs2),
    .dispatch_qj(x_dispatch_qj), .dispatch_qk(x_dispatch_qk), .dispatch_stall(x_dispatch_stall),
    .issue_en(x_issue_en), .issue_fu(x_issue_fu),
    .issue_rd(x_issue_rd), .issue_rs1(x_issue_rs1), .issue_rs2(x_issue_rs2),
    .wb_en(x_wb_en), .wb_tag(x_wb_tag), .busy(x_busy), .ready(x_ready)
  );

  // c_* flags select which expectations apply; comb/now are sampled before the
  // falling edge, post values at the next rising edge after the state update.
  typedef struct {
    string       name;
    bit          c_stall; logic s;
    bit          c_iss;   logic [14:0] iss;
    bit          c_now;   logic [3:0] nb; logic [3:0] nr;
    bit          c_post;  logic [3:0] pb; logic [3:0] pr;
    bit          c_x;     logic xs; logic [14:0] xiss; logic [5:0] xpb;
  } rec_t;

  rec_t q[$];
  rec_t r;
  rec_t mcur;
  bit   mhave;
  int   errors;
  int   checks;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic rec_t mk(string nm);
    rec_t t;
    t.name = nm;
    t.c_stall = 0; t.s = 0; t.c_iss = 0; t.iss = 0;
    t.c_now = 0; t.nb = 0; t.nr = 0; t.c_post = 0; t.pb = 0; t.pr = 0;
    t.c_x = 0; t.xs = 0; t.xiss = 0; t.xpb = 0;
    return t;
  endfunction

  initial begin : monitor
    mhave = 0;
    forever begin
      @(posedge CLK);
      if (mhave) begin
        if (mcur.c_post) begin
          chk({mcur.name, ".busy"}, 32'(busy), 32'(mcur.pb));
          chk({mcur.name, ".ready"}, 32'(ready), 32'(mcur.pr));
        end
        if (mcur.c_x) chk({mcur.name, ".x_busy"}, 32'(x_busy), 32'(mcur.xpb));
        mhave = 0;
      end
      #3;
      if (q.size() > 0) begin
        mcur  = q.pop_front();
        mhave = 1;
        if (mcur.c_stall) chk({mcur.name, ".stall"}, 32'(dispatch_stall), 32'(mcur.s));
        if (mcur.c_iss) chk({mcur.name, ".issue_fields"}, 32'({issue_rd, issue_rs1, issue_rs2}), 32'(mcur.iss));
        if (mcur.c_now) begin
          chk({mcur.name, ".busy_now"}, 32'(busy), 32'(mcur.nb));
          chk({mcur.name, ".ready_now"}, 32'(ready), 32'(mcur.nr));
        end
        if (mcur.c_x) begin
          chk({mcur.name, ".x_stall"}, 32'(x_dispatch_stall), 32'(mcur.xs));
          chk({mcur.name, ".x_issue_fields"}, 32'({x_issue_rd, x_issue_rs1, x_issue_rs2}), 32'(mcur.xiss));
        end
      end
    end
  end

  task automatic clr();
    dispatch_en = 0; dispatch_fu = 0; dispatch_rd = 0; dispatch_rs1 = 0; dispatch_rs2 = 0;
    dispatch_qj = 0; dispatch_qk = 0; issue_en = 0; issue_fu = 0; wb_en = 0; wb_tag = 0;
    x_dispatch_en = 0; x_dispatch_fu = 0; x_dispatch_rd = 0; x_dispatch_rs1 = 0; x_dispatch_rs2 = 0;
    x_dispatch_qj = 0; x_dispatch_qk = 0; x_issue_en = 0; x_issue_fu = 0; x_wb_en = 0; x_wb_tag = 0;
  endtask

  task automatic cyc(string nm);
    @(posedge CLK);
    #1;
    clr();
    r = mk(nm);
  endtask

  task automatic disp(int fu, int rd, int rs1, int rs2, int qj, int qk);
    dispatch_en = 1; dispatch_fu = 2'(fu);
    dispatch_rd = 5'(rd); dispatch_rs1 = 5'(rs1); dispatch_rs2 = 5'(rs2);
    dispatch_qj = 3'(qj); dispatch_qk = 3'(qk);
  endtask

  task automatic wb(int tag);
    wb_en = 1; wb_tag = 3'(tag);
  endtask

  task automatic iss(int fu);
    issue_en = 1; issue_fu = 2'(fu);
  endtask

  task automatic e_stall(logic s);
    r.c_stall = 1; r.s = s;
  endtask

  task automatic e_iss(int rd, int rs1, int rs2);
    r.c_iss = 1; r.iss = {5'(rd), 5'(rs1), 5'(rs2)};
  endtask

  task automatic e_post(logic [3:0] b, logic [3:0] rr);
    r.c_post = 1; r.pb = b; r.pr = rr;
  endtask

  task automatic e_x(logic s, logic [14:0] f, logic [5:0] b);
    r.c_x = 1; r.xs = s; r.xiss = f; r.xpb = b;
  endtask

  task automatic push();
    q.push_back(r);
  endtask

  initial begin : stim
    errors = 0;
    checks = 0;
    nRST = 0;
    clr();

    cyc("rst_hold"); nRST = 0; disp(0, 1, 1, 1, 1, 0); wb(1);
    e_stall(0); e_iss(0, 0, 0); r.c_now = 1; r.nb = 4'b0000; r.nr = 4'b0000;
    e_post(4'b0000, 4'b0000); push();

    cyc("release"); nRST = 1; e_post(4'b0000, 4'b0000); push();

    cyc("disp_fu2"); disp(2, 7, 3, 4, 0, 0); e_stall(0); e_post(4'b0100, 4'b0100);
    x_dispatch_en = 1; x_dispatch_fu = 5; x_dispatch_rd = 3; x_dispatch_rs1 = 4; x_dispatch_rs2 = 5;
    e_x(0, 15'd0, 6'b100000); push();

    cyc("issue_fu2"); iss(2); e_iss(7, 3, 4); e_post(4'b0100, 4'b0000);
    x_dispatch_en = 1; x_dispatch_fu = 7; x_issue_fu = 6;
    e_x(0, 15'd0, 6'b100000); push();

    cyc("wb3"); wb(3); e_post(4'b0000, 4'b0000);
    x_issue_fu = 5; x_wb_en = 1; x_wb_tag = 7;
    e_x(0, {5'd3, 5'd4, 5'd5}, 6'b100000); push();

    cyc("disp_fu1"); disp(1, 1, 2, 3, 0, 0); e_post(4'b0010, 4'b0010); push();
    cyc("disp_fu0_dep"); disp(0, 5, 6, 8, 2, 0); e_stall(0); e_post(4'b0011, 4'b0010); push();
    cyc("wb_tag0"); wb(0); e_post(4'b0011, 4'b0010); push();
    cyc("wb_tag7"); wb(7); e_post(4'b0011, 4'b0010); push();
    cyc("issue_notready"); iss(0); e_iss(5, 6, 8); e_post(4'b0011, 4'b0010); push();
    cyc("wb2_clear_dep"); wb(2); e_post(4'b0001, 4'b0001); push();
    cyc("disp_fu3"); disp(3, 9, 10, 11, 1, 0); e_post(4'b1001, 4'b0001); push();

    cyc("stall_busy3"); disp(3, 20, 21, 22, 0, 0); issue_fu = 3;
    e_stall(1); e_iss(9, 10, 11); e_post(4'b1001, 4'b0001); push();

    cyc("reuse3"); disp(3, 20, 21, 22, 0, 0); wb(4); e_stall(0); e_post(4'b1001, 4'b1001); push();
    cyc("read3_issue"); iss(3); e_iss(20, 21, 22); e_post(4'b1001, 4'b0001); push();
    cyc("wb_issue_fu0"); wb(1); iss(0); e_post(4'b1000, 4'b0000); push();
    cyc("disp_fu1b"); disp(1, 2, 0, 0, 0, 0); e_post(4'b1010, 4'b0010); push();

    cyc("bypass_qj"); disp(0, 12, 13, 14, 2, 0); wb(2);
`ifdef FUST_MULTI_WB_BYPASS_EN
    e_stall(0); e_post(4'b1001, 4'b0001);
`else
    e_stall(1); e_post(4'b1000, 4'b0000);
`endif
    push();

    cyc("retry"); disp(0, 12, 13, 14, 0, 0);
`ifdef FUST_MULTI_WB_BYPASS_EN
    e_stall(1); e_post(4'b1001, 4'b0001);
`else
    e_stall(0); e_post(4'b1001, 4'b0001);
`endif
    push();

    cyc("dep_qk"); disp(1, 3, 3, 3, 0, 1); wb(1);
`ifdef FUST_MULTI_WB_BYPASS_EN
    e_stall(0); e_post(4'b1010, 4'b0010);
`else
    e_stall(1); e_post(4'b1000, 4'b0000);
`endif
    push();

    cyc("fill_fu2"); disp(2, 1, 1, 1, 0, 0); push();
    cyc("fill_fu0"); disp(0, 1, 1, 1, 0, 0);
`ifdef FUST_MULTI_WB_BYPASS_EN
    e_post(4'b1111, 4'b0111);
`else
    e_post(4'b1101, 4'b0101);
`endif
    push();

    cyc("reset_mid"); nRST = 0; disp(1, 4, 4, 4, 0, 0); issue_fu = 2;
    e_stall(0); e_iss(0, 0, 0); r.c_now = 1; r.nb = 4'b0000; r.nr = 4'b0000;
    e_post(4'b0000, 4'b0000); push();

    cyc("release2"); nRST = 1; e_post(4'b0000, 4'b0000); push();
    cyc("disp_after_reset"); disp(1, 4, 4, 4, 0, 0); e_stall(0); e_post(4'b0010, 4'b0010); push();

    cyc("idle_end"); push();
    repeat (2) @(posedge CLK);
    for (int i = 0; i < 20 && (q.size() > 0 || mhave); i++) @(posedge CLK);
    if (q.size() > 0 || mhave) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending records expected 0", q.size());
    end
    #4;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
